// File: rtl/mult_seq_pkg.sv
// Shared types and default parameters for the multiplier operand sequencer.
//   seq_state_e : sequencer FSM state encoding
//   *_DEF       : default operand width, FIFO depth and multiplier latency
package mult_seq_pkg;

   localparam int unsigned WIDTH_DEF    = 4;
   localparam int unsigned DEPTH_DEF    = 4;
   localparam int unsigned MULT_LAT_DEF = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/mult_operand_fifo.sv
// Synchronous FIFO buffering packed {a, b} operand pairs.
//   clk, n_rst  : clock, synchronous active-low reset
//   push, wdata : write request and data (ignored when full)
//   pop, rdata  : read request; rdata shows the head entry
//   full, empty : occupancy flags
//   count       : number of stored entries
module mult_operand_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      push,
   input  logic [DATA_W-1:0]         wdata,
   input  logic                      pop,
   output logic [DATA_W-1:0]         rdata,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = cnt_q;

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Feeds operand pairs to a fixed-latency shift-add multiplier and returns
// its products downstream in arrival order.
//   clk, n_rst                : clock, synchronous active-low reset
//   in_valid/in_ready/in_a/b  : operand pair input handshake
//   mul_start/mul_a/mul_b     : start pulse and operands to the multiplier
//   mul_product               : multiplier result, sampled after MULT_LAT
//   out_valid/out_ready       : result handshake
//   out_product               : captured product
module mult_operand_sequencer
   import mult_seq_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH = DEPTH_DEF,
   parameter int unsigned MULT_LAT   = MULT_LAT_DEF
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_product,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product
);

   localparam int unsigned DATA_W = 2 * WIDTH;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned LAT_W  = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

   seq_state_e         state_q, state_d;
   logic [LAT_W-1:0]   cnt_q, cnt_d;
   logic               mul_start_q, mul_start_d;
   logic [WIDTH-1:0]   mul_a_q, mul_a_d;
   logic [WIDTH-1:0]   mul_b_q, mul_b_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_product_q, out_product_d;

   logic               fifo_push, fifo_pop;
   logic [DATA_W-1:0]  fifo_rdata;
   logic               fifo_full, fifo_empty;
   logic [FCNT_W-1:0]  fifo_count;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

   mult_operand_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (fifo_push),
      .wdata ({in_a, in_b}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fifo_count != '0) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (cnt_q == '0) state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; the start pulse is set on the way into
   // ISSUE so that the registered mul_start is high only during ISSUE.
   always_comb begin
      mul_start_d   = 1'b0;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      cnt_d         = cnt_q;
      out_valid_d   = out_valid_q;
      out_product_d = out_product_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               mul_a_d     = fifo_rdata[DATA_W-1:WIDTH];
               mul_b_d     = fifo_rdata[WIDTH-1:0];
               mul_start_d = 1'b1;
            end
         end
         ISSUE: cnt_d = LAT_W'(MULT_LAT - 1);
         WAIT: begin
            if (cnt_q == '0) begin
               out_product_d = mul_product;
               out_valid_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         HOLD:    if (out_ready) out_valid_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q         <= '0;
         mul_start_q   <= 1'b0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
      end else begin
         cnt_q         <= cnt_d;
         mul_start_q   <= mul_start_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         out_valid_q   <= out_valid_d;
         out_product_q <= out_product_d;
      end
   end

   assign mul_start   = mul_start_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign out_valid   = out_valid_q;
   assign out_product = out_product_q;

endmodule

// File: doc/mult_operand_sequencer.md
Name: mult_operand_sequencer

Overview:
Upstream feeder and result collector for the 4-bit shift-add multiplier (shift_add_multi).
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Drives the multiplier's operands and issues its one-cycle start pulse.
- The multiplier has no done flag, so the block waits a fixed latency, then samples product.
- Presents the result downstream with valid/ready and stalls under backpressure.

Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH.
- FIFO_DEPTH, 4, operand FIFO entries; must be a power of 2, at least 2.
- MULT_LAT, 6, cycles from the mul_start cycle to the cycle mul_product is sampled; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept (= !full).
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_a  out  WIDTH  operand a to multiplier; registered.
- mul_b  out  WIDTH  operand b to multiplier; registered.
- mul_product  in  2*WIDTH  product from multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_product  out  2*WIDTH  captured product; registered.

Behaviour:
- Reset (n_rst=0 at a rising edge):
  - state=IDLE; FIFO pointers and count=0.
  - mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_product=0, wait counter=0.
  - in_ready=1 in the cycle after reset.
  - Reset during any state aborts the operation and flushes the FIFO; a product already in flight is discarded.
- FIFO:
  - Push when in_valid && in_ready. Pop only in IDLE when count != 0.
  - Push and pop in the same cycle: count unchanged.
  - in_ready = (count != FIFO_DEPTH). A push is impossible when full, and in_valid is ignored then.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- FSM, states IDLE / ISSUE / WAIT / HOLD:
  - IDLE: if count != 0, pop the head into mul_a/mul_b and go to ISSUE; otherwise stay.
  - ISSUE: mul_start=1 for exactly this cycle; load cnt=MULT_LAT-1; go to WAIT.
  - WAIT: if cnt==0, capture out_product<=mul_product, set out_valid=1, go to HOLD; else cnt<=cnt-1.
  - HOLD: out_valid=1 and out_product stable. On out_ready, clear out_valid and go to IDLE.
  - mul_start is 0 in every state except ISSUE.
- Timing:
  - mul_a/mul_b are stable from ISSUE through WAIT.
  - Product is sampled at the end of cycle T+MULT_LAT, where T is the ISSUE cycle.
  - Latency with an empty pipe: accept at cycle N gives out_valid high at N+3+MULT_LAT (9 cycles at default).
  - Throughput: one result per MULT_LAT+3 cycles when out_ready=1.
- Arithmetic: no arithmetic in this block; product is passed through unmodified at 2*WIDTH bits, so no overflow is possible.
- Backpressure: out_valid stays high until out_ready. The FIFO keeps accepting until full; no further issue happens while in HOLD.
- Ordering: results are produced in strict FIFO order of accepted inputs.

Decomposition:
- Package mult_seq_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, HOLD) as a 2-bit typedef;
  - default constants WIDTH_DEF=4, DEPTH_DEF=4, MULT_LAT_DEF=6.
- One sub-module, mult_operand_fifo: a synchronous FIFO with data width 2*WIDTH and depth FIFO_DEPTH, providing push/pop, full/empty and count.
- The FSM, wait counter and output registers live in the top.
- The bench instantiates shift_add_multi as the real downstream multiplier, with MULT_LAT matched to its latency.

Test Plan:
- Reset, then a=3, b=2 pushed at cycle N -> mul_start high exactly one cycle at N+2 with mul_a=3, mul_b=2; out_valid at N+9 with out_product=6.
- Three back-to-back pairs (15,15), (0,9), (1,1) with out_ready=1 -> outputs 225, 0, 1 in order, spaced 9 cycles apart.
- out_ready=0 while 5 pairs are pushed -> out_valid=1 holding the first product; in_ready drops after the FIFO fills with 4 pending. Releasing out_ready drains all 5 in order.
- Push and pop in the same cycle while count=2 -> count stays 2 and in_ready stays 1.
- n_rst=0 during WAIT with 2 entries queued -> next cycle out_valid=0, mul_start=0, in_ready=1. No stale result appears; a new pair (5,3) later yields 15.
- Each of a=0..15 with b=15 -> out_product equals a*15 (max 225); no width truncation.
